// File: rtl/serial_host_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_host_cmd_pkg: protocol constants, FSM states, bit timing      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package serial_host_cmd_pkg;

  localparam logic [7:0] ACK_BYTE_DEFAULT = 8'hAC;
  localparam int         RW_BIT           = 7;
  localparam logic [2:0] RSVD_BITS        = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_CMD  = 3'd1,
    ST_SEND_REG  = 3'd2,
    ST_SEND_DATA = 3'd3,
    ST_WAIT_RSP  = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  function automatic int bit_cycles(input int clk_frequency, input int baud);
    return clk_frequency / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_host_cmd_host_uart.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | host_uart: 8N1 byte transmitter and free-running byte receiver       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module host_uart
  import serial_host_cmd_pkg::*;
#(
  parameter int CLK_FREQUENCY = 50_000_000,
  parameter int BAUD          = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_active,
  output logic       rx_valid,
  output logic       rx_framing_err,
  output logic [7:0] rx_data
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQUENCY, BAUD);
  localparam int CW         = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_HALF = CW'(BIT_CYCLES / 2 - 1);

  logic          tx_active_q, tx_active_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [CW-1:0] tx_cyc_q, tx_cyc_d;

  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic          rx_active_q, rx_active_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [CW-1:0] rx_cyc_q, rx_cyc_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;

  // A start request on the final stop-bit cycle reloads the shifter, so frames abut.
  always_comb begin
    tx_active_d = tx_active_q;
    tx_shift_d  = tx_shift_q;
    tx_bit_d    = tx_bit_q;
    tx_cyc_d    = tx_cyc_q;
    tx_done     = tx_active_q && (tx_bit_q == 4'd9) && (tx_cyc_q == CYC_LAST);
    if (tx_active_q) begin
      if (tx_cyc_q == CYC_LAST) begin
        tx_cyc_d   = '0;
        tx_bit_d   = tx_bit_q + 4'd1;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        if (tx_done) tx_active_d = 1'b0;
      end else begin
        tx_cyc_d = tx_cyc_q + CW'(1);
      end
    end
    if (tx_start && (!tx_active_q || tx_done)) begin
      tx_active_d = 1'b1;
      tx_shift_d  = {1'b1, tx_data, 1'b0};
      tx_bit_d    = 4'd0;
      tx_cyc_d    = '0;
    end
  end

  assign txd = tx_active_q ? tx_shift_q[0] : 1'b1;

  // Bit index 0 is the start bit (checked at half a bit); 1..8 data; 9 stop.
  always_comb begin
    rx_s1_d     = rxd;
    rx_s2_d     = rx_s1_q;
    rx_prev_d   = rx_s2_q;
    rx_active_d = rx_active_q;
    rx_bit_d    = rx_bit_q;
    rx_cyc_d    = rx_cyc_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_ferr_d   = 1'b0;
    if (!rx_active_q) begin
      if (rx_prev_q && !rx_s2_q) begin
        rx_active_d = 1'b1;
        rx_bit_d    = 4'd0;
        rx_cyc_d    = '0;
      end
    end else if (rx_bit_q == 4'd0) begin
      if (rx_cyc_q == CYC_HALF) begin
        if (rx_s2_q) begin
          rx_active_d = 1'b0;
        end else begin
          rx_bit_d = 4'd1;
          rx_cyc_d = '0;
        end
      end else begin
        rx_cyc_d = rx_cyc_q + CW'(1);
      end
    end else if (rx_cyc_q == CYC_LAST) begin
      rx_cyc_d = '0;
      if (rx_bit_q == 4'd9) begin
        rx_active_d = 1'b0;
        if (rx_s2_q) begin
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shift_q;
        end else begin
          rx_ferr_d = 1'b1;
        end
      end else begin
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 4'd1;
      end
    end else begin
      rx_cyc_d = rx_cyc_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_active_q <= 1'b0;
      tx_shift_q  <= '1;
      tx_bit_q    <= '0;
      tx_cyc_q    <= '0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_active_q <= 1'b0;
      rx_bit_q    <= '0;
      rx_cyc_q    <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ferr_q   <= 1'b0;
    end else begin
      tx_active_q <= tx_active_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      tx_cyc_q    <= tx_cyc_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_prev_q   <= rx_prev_d;
      rx_active_q <= rx_active_d;
      rx_bit_q    <= rx_bit_d;
      rx_cyc_q    <= rx_cyc_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_ferr_q   <= rx_ferr_d;
    end
  end

  assign rx_active      = rx_active_q;
  assign rx_valid       = rx_valid_q;
  assign rx_framing_err = rx_ferr_q;
  assign rx_data        = rx_data_q;

endmodule
`default_nettype wire

// File: rtl/serial_host_cmd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_host_cmd: register read/write initiator over an 8N1 link      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module serial_host_cmd
  import serial_host_cmd_pkg::*;
#(
  parameter int         CLK_FREQUENCY     = 50_000_000,
  parameter int         BAUD              = 115_200,
  parameter int         DBUS_WIDTH        = 8,
  parameter int         PERIPH_ADDR_WIDTH = 4,
  parameter int         REG_ADDR_WIDTH    = 8,
  parameter int         TIMEOUT_BYTES     = 4,
  parameter logic [7:0] ACK_BYTE          = ACK_BYTE_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rxd,
  output logic                         txd,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_rw,
  input  logic [PERIPH_ADDR_WIDTH-1:0] cmd_periph,
  input  logic [REG_ADDR_WIDTH-1:0]    cmd_reg,
  input  logic [DBUS_WIDTH-1:0]        cmd_wdata,
  output logic                         rsp_valid,
  output logic [DBUS_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic                         busy
);

  localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * bit_cycles(CLK_FREQUENCY, BAUD);
  localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES);

  state_e                  state_q, state_d;
  logic                    rw_q, rw_d;
  logic [REG_ADDR_WIDTH-1:0] reg_q, reg_d;
  logic [DBUS_WIDTH-1:0]   wdata_q, wdata_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [DBUS_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic       tx_start, tx_done, rx_active, rx_valid, rx_ferr;
  logic [7:0] tx_data, rx_data, byte0;

  host_uart #(
    .CLK_FREQUENCY(CLK_FREQUENCY),
    .BAUD         (BAUD)
  ) u_uart (
    .clk           (clk),
    .reset         (reset),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_done       (tx_done),
    .txd           (txd),
    .rxd           (rxd),
    .rx_active     (rx_active),
    .rx_valid      (rx_valid),
    .rx_framing_err(rx_ferr),
    .rx_data       (rx_data)
  );

  // Byte0 goes straight into the TX shifter at acceptance, so periph needs no holding register.
  always_comb begin
    byte0         = '0;
    byte0[RW_BIT] = cmd_rw;
    byte0[6:4]    = RSVD_BITS;
    byte0[3:0]    = cmd_periph;
  end

  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    timer_d  = timer_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tx_start = 1'b0;
    tx_data  = byte0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          rw_d     = cmd_rw;
          reg_d    = cmd_reg;
          wdata_d  = cmd_wdata;
          tx_start = 1'b1;
          state_d  = ST_SEND_CMD;
        end
      end
      ST_SEND_CMD: begin
        if (tx_done) begin
          tx_start = 1'b1;
          tx_data  = reg_q;
          state_d  = ST_SEND_REG;
        end
      end
      ST_SEND_REG: begin
        if (tx_done) begin
          if (!rw_q) begin
            tx_start = 1'b1;
            tx_data  = wdata_q;
            state_d  = ST_SEND_DATA;
          end else begin
            timer_d = TIMEOUT_LOAD;
            state_d = ST_WAIT_RSP;
          end
        end
      end
      ST_SEND_DATA: begin
        if (tx_done) begin
          timer_d = TIMEOUT_LOAD;
          state_d = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        // A byte in flight holds off the timeout so a late reply still lands.
        if (rx_valid) begin
          state_d = ST_DONE;
          if (rw_q) begin
            rdata_d = rx_data;
            err_d   = 1'b0;
          end else begin
            err_d = (rx_data != ACK_BYTE);
          end
        end else if (rx_ferr) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (!rx_active) begin
          if (timer_q == TW'(1)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rw_q    <= 1'b0;
      reg_q   <= '0;
      wdata_q <= '0;
      timer_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = !cmd_ready;
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_host_cmd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_host_cmd: directed vectors with a UART responder model     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_serial_host_cmd;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       txd;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [3:0] cmd_periph = '0;
  logic [7:0] cmd_reg = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;

  serial_host_cmd #(
    .CLK_FREQUENCY(1_000_000),
    .BAUD         (100_000),
    .TIMEOUT_BYTES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .txd       (txd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_periph(cmd_periph),
    .cmd_reg   (cmd_reg),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rw;
    logic [3:0] periph;
    logic [7:0] regaddr;
    logic [7:0] wdata;
    logic [7:0] reply;
    logic       reply_stop;
    logic [7:0] exp_b0;
    logic [7:0] exp_b1;
    logic [7:0] exp_b2;
    logic       exp_err;
    logic       chk_rdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc_cnt = 0;
  int   rsp_count = 0;
  int   rsp_cyc = 0;
  logic last_err;
  logic [7:0] last_rdata;
  int   ready_viol = 0;
  int   busy_viol = 0;
  bit   in_txn = 0;
  logic tx_line [1:300];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (busy !== !cmd_ready) busy_viol++;
    if (in_txn && cmd_ready === 1'b1) ready_viol++;
    if (rsp_valid === 1'b1) begin
      rsp_count++;
      last_err   = rsp_err;
      last_rdata = rsp_rdata;
      rsp_cyc    = cyc_cnt;
      in_txn     = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Handshake, then record txd for every cycle of the expected frames and decode.
  task automatic issue(input vec_t v, input string tag, output int acc);
    int nb;
    logic [7:0] eb, dec;
    logic [9:0] pat;
    logic ok;
    nb = v.rw ? 2 : 3;
    @(negedge clk);
    check({tag, " ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid  = 1'b1;
    cmd_rw     = v.rw;
    cmd_periph = v.periph;
    cmd_reg    = v.regaddr;
    cmd_wdata  = v.wdata;
    @(posedge clk);
    #1;
    acc        = cyc_cnt;
    in_txn     = 1;
    cmd_valid  = 1'b0;
    cmd_rw     = ~v.rw;
    cmd_periph = ~v.periph;
    cmd_reg    = ~v.regaddr;
    cmd_wdata  = ~v.wdata;
    for (int k = 1; k <= nb * 100; k++) begin
      @(negedge clk);
      tx_line[k] = txd;
    end
    for (int b = 0; b < nb; b++) begin
      eb  = (b == 0) ? v.exp_b0 : ((b == 1) ? v.exp_b1 : v.exp_b2);
      pat = {1'b1, eb, 1'b0};
      ok  = 1'b1;
      dec = '0;
      for (int i = 0; i < 10; i++) begin
        for (int j = 1; j <= 10; j++)
          if (tx_line[b * 100 + i * 10 + j] !== pat[i]) ok = 1'b0;
        if (i >= 1 && i <= 8) dec[i-1] = tx_line[b * 100 + i * 10 + 5];
      end
      check($sformatf("%s txbyte%0d", tag, b), {23'd0, ok, dec}, {23'd0, 1'b1, eb});
    end
    @(negedge clk);
    check({tag, " txd idle after frames"}, {31'd0, txd}, 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] data, input logic stop);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (10) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic wait_rsp(input int base, input string tag);
    int n;
    n = 0;
    while (rsp_count == base && n < 1500) begin
      @(negedge clk);
      n++;
    end
    if (rsp_count == base) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s rsp timeout: no rsp_valid within 1500 cycles, required one", tag);
    end
    repeat (3) @(negedge clk);
    check({tag, " rsp pulse count"}, rsp_count - base, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int base, acc;
    base = rsp_count;
    issue(v, tag, acc);
    repeat (20) @(negedge clk);
    send_rx(v.reply, v.reply_stop);
    wait_rsp(base, tag);
    check({tag, " rsp_err"}, {31'd0, last_err}, {31'd0, v.exp_err});
    if (v.chk_rdata) check({tag, " rsp_rdata"}, {24'd0, last_rdata}, {24'd0, v.exp_rdata});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc, base;
    vec_t v;
    //             rw    per   reg    wdata  reply  stop  b0     b1     b2     err   chk   rdata
    vecs[0] = '{1'b0, 4'h1, 8'h02, 8'h5A, 8'hAC, 1'b1, 8'h01, 8'h02, 8'h5A, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{1'b1, 4'h1, 8'h03, 8'h00, 8'h3C, 1'b1, 8'h81, 8'h03, 8'h00, 1'b0, 1'b1, 8'h3C};
    vecs[2] = '{1'b0, 4'hF, 8'hFF, 8'h00, 8'h55, 1'b1, 8'h0F, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h3C};
    vecs[3] = '{1'b1, 4'h7, 8'hA5, 8'h00, 8'hC3, 1'b0, 8'h87, 8'hA5, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 4'h0, 8'h00, 8'h00, 8'hFF, 1'b1, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF};
    vecs[5] = '{1'b0, 4'h3, 8'h10, 8'hA5, 8'hAC, 1'b1, 8'h03, 8'h10, 8'hA5, 1'b0, 1'b1, 8'hFF};

    repeat (5) @(negedge clk);
    check("reset txd", {31'd0, txd}, 32'd1);
    check("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    check("reset rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Silent target: reply deadline 400 cycles past the end of the last stop bit.
    v = '{1'b1, 4'h2, 8'h44, 8'h00, 8'h00, 1'b1, 8'h82, 8'h44, 8'h00, 1'b1, 1'b1, 8'hFF};
    base = rsp_count;
    issue(v, "timeout", acc);
    wait_rsp(base, "timeout");
    check("timeout latency", rsp_cyc - acc, 32'd600);
    check("timeout rsp_err", {31'd0, last_err}, 32'd1);
    check("timeout rsp_rdata kept", {24'd0, last_rdata}, 32'hFF);

    // Short low glitch on rxd must not produce a byte.
    v = '{1'b1, 4'h4, 8'h20, 8'h00, 8'h96, 1'b1, 8'h84, 8'h20, 8'h00, 1'b0, 1'b1, 8'h96};
    base = rsp_count;
    issue(v, "glitch", acc);
    repeat (50) @(negedge clk);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (150) @(negedge clk);
    check("glitch no rsp", rsp_count - base, 32'd0);
    send_rx(v.reply, 1'b1);
    wait_rsp(base, "glitch");
    check("glitch rsp_err", {31'd0, last_err}, 32'd0);
    check("glitch rsp_rdata", {24'd0, last_rdata}, 32'h96);

    // Reset in the middle of byte1 (0x66 bit3, a low bit).
    base = rsp_count;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_rw     = 1'b0;
    cmd_periph = 4'h5;
    cmd_reg    = 8'h66;
    cmd_wdata  = 8'h11;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (145) @(negedge clk);
    check("midbyte1 txd low", {31'd0, txd}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post-reset txd", {31'd0, txd}, 32'd1);
    check("post-reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("post-reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post-reset rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    reset = 1'b0;
    repeat (500) @(negedge clk);
    check("post-reset no rsp", rsp_count - base, 32'd0);
    v = '{1'b0, 4'h5, 8'h66, 8'h11, 8'hAC, 1'b1, 8'h05, 8'h66, 8'h11, 1'b0, 1'b1, 8'h00};
    run_vec(v, "after-reset");

    check("cmd_ready low during txn", ready_viol, 32'd0);
    check("busy equals !cmd_ready", busy_viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_host_cmd.md
Name: serial_host_cmd

Overview:
- Host-side initiator for the serial_fpga register protocol: drives a serial_fpga master's rxd and listens on its txd.
- Accepts one register read/write request over a valid/ready handshake, serialises it as 8N1 UART bytes, waits for the target's reply and returns data or error.
- Used in FPGA-to-FPGA setups and as the self-checking stimulus engine for HBA peripheral test projects.

Parameters:
- CLK_FREQUENCY, 50_000_000, clk frequency in Hz.
- BAUD, 115_200, serial bit rate.
- DBUS_WIDTH, 8, register data width; fixed at 8.
- PERIPH_ADDR_WIDTH, 4, peripheral (slot) address width; fixed at 4.
- REG_ADDR_WIDTH, 8, register address width; fixed at 8.
- TIMEOUT_BYTES, 4, reply timeout in byte times (10 bit periods each).
- ACK_BYTE, 8'hAC, byte the target returns after a write.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  serial in, from target txd; asynchronous.
- txd  output  1  serial out, to target rxd.
- cmd_valid  input  1  request present.
- cmd_ready  output  1  block can accept a request.
- cmd_rw  input  1  0 = write, 1 = read.
- cmd_periph  input  PERIPH_ADDR_WIDTH  target peripheral address.
- cmd_reg  input  REG_ADDR_WIDTH  target register address.
- cmd_wdata  input  DBUS_WIDTH  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse: transaction finished.
- rsp_rdata  output  DBUS_WIDTH  read data; held until the next rsp_valid.
- rsp_err  output  1  qualifies rsp_valid: timeout, framing error or bad ack.
- busy  output  1  transaction in progress (equals !cmd_ready).

Behaviour:
- BIT_CYCLES = CLK_FREQUENCY/BAUD, truncated; 434 at the defaults.
- UART frame: 8N1, LSB first; txd idles high.
- Reset values: txd=1, cmd_ready=1, busy=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, state IDLE.
- Handshake:
  - Request accepted on the clk where cmd_valid && cmd_ready.
  - All cmd_* fields are latched at acceptance; later changes have no effect.
  - cmd_ready=1 only in IDLE.
- Byte sequence:
  - Byte0 = {cmd_rw, 3'b000, cmd_periph}.
  - Byte1 = cmd_reg.
  - Byte2 = cmd_wdata, writes only.
- Timing:
  - Start bit of byte0 begins on the clk after acceptance.
  - Bytes are sent back-to-back: next start bit follows the previous stop bit with no idle gap.
- States:
  - IDLE -> SEND_CMD on acceptance.
  - SEND_CMD -> SEND_REG after byte0.
  - SEND_REG -> SEND_DATA (write) or WAIT_RSP (read).
  - SEND_DATA -> WAIT_RSP after byte2.
  - WAIT_RSP -> DONE when a reply byte arrives or the timeout expires.
  - DONE -> IDLE after one cycle; rsp_valid=1 in DONE.
- Reply handling:
  - Read: the received byte goes to rsp_rdata; rsp_err=0.
  - Write: received byte == ACK_BYTE gives rsp_err=0, otherwise rsp_err=1; rsp_rdata is unchanged on writes.
- Timeout:
  - Counter loads at the end of the last stop bit transmitted.
  - Runs TIMEOUT_BYTES*10*BIT_CYCLES cycles; it is frozen while a reply byte is being received.
  - Expiry sets rsp_err=1 and leaves rsp_rdata unchanged.
- RX path:
  - rxd passes through a 2-flop synchroniser.
  - A falling edge starts a frame; the start bit is rechecked at BIT_CYCLES/2 and the frame is aborted if high (false start, ignored).
  - Data bits and stop bit are sampled at mid-bit.
  - Stop bit = 0 is a framing error: in WAIT_RSP it gives rsp_err=1, otherwise the byte is dropped.
- Bytes completed outside WAIT_RSP are discarded; the RX engine runs continuously.
- Reset mid-transaction:
  - Next cycle txd=1 and the state returns to IDLE.
  - No rsp_valid is produced and partial RX is discarded.
  - A truncated frame on the wire is acceptable.

Decomposition:
- Shared package holds:
  - Protocol constants: ACK_BYTE, bit-7 RW position, reserved-bit value 3'b000.
  - State encoding for IDLE/SEND_CMD/SEND_REG/SEND_DATA/WAIT_RSP/DONE.
  - BIT_CYCLES derivation function.
- One sub-module, host_uart, is natural: byte TX with start/done and byte RX with valid/framing_err, parameterised by CLK_FREQUENCY/BAUD.
- serial_host_cmd keeps the sequencing FSM, timeout counter and response registers.

Test Plan:
Simulation parameters CLK_FREQUENCY=1_000_000, BAUD=100_000 (BIT_CYCLES=10); the behavioural target model is a UART responder.
- Write: periph=1, reg=0x02, wdata=0x5A -> txd carries 0x01,0x02,0x5A, first start bit at acceptance+1, 300 cycles total; model replies 0xAC -> rsp_valid pulse, rsp_err=0.
- Read: rw=1, periph=1, reg=0x03 -> txd carries 0x81,0x03; model replies 0x3C -> rsp_rdata=0x3C, rsp_err=0; cmd_ready low for the whole transaction.
- Silent target, TIMEOUT_BYTES=4 -> rsp_valid with rsp_err=1 exactly 400 cycles after the final stop bit; rsp_rdata retains its previous value.
- Write reply 0x55, then a read reply with stop bit forced 0 -> both return rsp_err=1.
- 5-cycle low glitch on rxd during WAIT_RSP -> no byte and no rsp_valid; a real reply afterwards completes normally.
- reset asserted mid-byte1 -> txd=1 and cmd_ready=1 next cycle, no rsp_valid; a new request then completes correctly.
